shift_right_issue: RTL

Sequencing front-end for the 4-bit `shift_right` datapath. It accepts operand pairs over a valid/ready handshake and registers them into the shifter. It captures each result with zero/saturation flags into a small result FIFO and presents results downstream over a second valid/ready handshake. It is the upstream issue stage and the downstream result buffer for the combinational shifter, which it instantiates.

---
 rtl/shift_issue_pkg.sv | 28 ++
 rtl/shift_result_fifo.sv | 52 +++++
 rtl/shift_right.sv | 10 +
 rtl/shift_right_issue.sv | 100 ++++++++++
 4 files changed

// File: rtl/shift_issue_pkg.sv
// Shared types and sizing helpers for the shift_right issue stage.
package shift_issue_pkg;

  localparam int FIFO_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] s;
    logic       zero;
    logic       sat;
  } result_t;

  // Width needed to hold an occupancy of 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width; a single-entry buffer still gets a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/shift_result_fifo.sv
// Circular result buffer between the issue FSM and the downstream consumer.
module shift_result_fifo
  import shift_issue_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH_DEF,
  localparam int CW    = cnt_width(DEPTH),
  localparam int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  result_t       push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output result_t       head
);

  result_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop on an empty buffer is ignored so the pointers never desynchronize.
  assign pop_ok = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Storage, pointers and occupancy; push and pop may happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop_ok) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/shift_right.sv
// Combinational 4-bit logical right shifter; amounts >= 4 clear the result.
module shift_right (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] s
);

  assign s = a >> b;

endmodule

// File: rtl/shift_right_issue.sv
// Issue stage and result buffer wrapped around the combinational shifter.
module shift_right_issue
  import shift_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_s,
  output logic             out_zero,
  output logic             out_sat,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  localparam int            CW      = cnt_width(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  state_t        state;
  logic [3:0]    op_a;
  logic [3:0]    op_b;
  logic [3:0]    s;
  result_t       res;
  result_t       head;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;

  // Accept only with a free slot; the slot stays free until WRITE since the
  // FIFO can only drain while the op is in flight.
  assign in_ready  = (state == IDLE) && (fifo_count < DEPTH_C);
  assign busy      = (state != IDLE);
  assign push      = (state == WRITE);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  assign out_s    = out_valid ? head.s    : 4'd0;
  assign out_zero = out_valid ? head.zero : 1'b0;
  assign out_sat  = out_valid ? head.sat  : 1'b0;

  shift_right u_shift (
    .a (op_a),
    .b (op_b),
    .s (s)
  );

  shift_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (res),
    .pop       (pop),
    .count     (fifo_count),
    .head      (head)
  );

  // Issue FSM: latch operands, capture the shifter result, then push it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_a  <= in_a;
            op_b  <= in_b;
            state <= EXEC;
          end
        end
        EXEC: begin
          res.s    <= s;
          res.zero <= (s == 4'd0);
          res.sat  <= op_b[3] | op_b[2];
          state    <= WRITE;
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Count results handed downstream; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count <= '0;
    else if (pop) op_count <= op_count + CNT_W'(1);
  end

endmodule
